// File: rtl/memory_pkg.sv
// Shared encodings for the memory bank: access-type codes and the controller state type.
package memory_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/memory_bank.sv
// Single-port register-array memory bank with one-cycle registered reads and a
// DEPTH-cycle zeroing sweep; ready is high only while the bank is idle.
module memory_bank
  import memory_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              select,
  input  logic              op,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_input,
  input  logic              clear,
  output logic              ready,
  output logic [DATA_W-1:0] data_output,
  output logic              valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign ready  = (state == IDLE);
  assign accept = select & ready & ~clear;

  // One write port shared by host writes and the clear sweep; reset blocks both.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = data_input;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = counter;
        wr_data = '0;
      end else if (accept && op == OP_WRITE) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      data_output <= '0;
      valid       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            state   <= CLEAR;
            counter <= '0;
          end else if (accept && op == OP_READ) begin
            data_output <= mem[address];
            valid       <= 1'b1;
          end
        end
        CLEAR: begin
          // Counter wraps naturally at DEPTH; the last word written ends the sweep.
          counter <= counter + 1'b1;
          if (counter == '1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_bank.md
MEMORY_BANK -- requirements
Module: memory_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; depth DEPTH = 2**ADDR_W words (derived, not overridable).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port select  input  1  request valid.
REQ-006 SHALL have port op  input  1  access type: 1 = write, 0 = read.
REQ-007 SHALL have port address  input  ADDR_W  word address.
REQ-008 SHALL have port data_input  input  DATA_W  write data.
REQ-009 SHALL have port clear  input  1  request to zero the whole array.
REQ-010 SHALL have port ready  output  1  high when a request or clear can be accepted.
REQ-011 SHALL have port data_output  output  DATA_W  registered read data.
REQ-012 SHALL have port valid  output  1  one-cycle strobe marking new data_output.

Function
REQ-013 SHALL use FSM states IDLE and CLEAR; ready = 1 exactly in IDLE.
REQ-014 SHALL accept a request on an edge where select & ready & ~clear are all high.
REQ-015 SHALL, on an accepted write, store data_input at address at that edge; valid stays 0; data_output unchanged.
REQ-016 SHALL, on an accepted read at edge N, load data_output with mem[address] at edge N and hold valid = 1 for exactly the following cycle (latency 1).
REQ-017 SHALL hold data_output at its last read value while valid = 0.
REQ-018 SHALL sustain one accepted request per cycle in IDLE (back-to-back reads/writes, no bubbles).
REQ-019 SHALL return newly written data for a read accepted on the edge immediately after the write to the same address.
REQ-020 SHALL, when clear & ready at an edge, enter CLEAR with sweep counter = 0; select at that edge is not accepted.
REQ-021 SHALL in CLEAR write 0 to mem[counter] each edge and increment counter; after writing DEPTH-1 (DEPTH cycles total) return to IDLE.
REQ-022 SHALL ignore select, op, address, data_input and clear while in CLEAR; valid = 0 throughout.
REQ-023 SHALL wrap the sweep counter modulo DEPTH with no overflow to other state.
REQ-024 SHALL never produce out-of-range addresses (all ADDR_W values are valid).

Reset
REQ-025 SHALL, while rst = 1 at an edge, set state = IDLE, counter = 0, data_output = 0, valid = 0; ready = 1 on the following cycle.
REQ-026 SHALL leave memory contents unchanged by reset; contents are undefined after power-up until written or cleared.
REQ-027 SHALL abort a CLEAR sweep when rst is asserted mid-sweep; already-zeroed words stay zero, the rest keep prior data.
REQ-028 SHALL give rst priority over clear and select at the same edge (no write, no read, no clear).

Structure
REQ-029 SHALL place op encodings (OP_READ = 0, OP_WRITE = 1) and the FSM state type in shared package memory_pkg.
REQ-030 SHALL implement the storage array inline as a register array of DEPTH x DATA_W; no sub-module required.

Verification
REQ-031 Bench SHALL write 8'hAA to address 4, then read address 4 -> valid high one cycle after the read edge, data_output = 8'hAA.
REQ-032 Bench SHALL write 8'h11..8'h88 to addresses 0..7 back-to-back, then read 0..7 back-to-back -> eight consecutive valid cycles returning 8'h11..8'h88 in order.
REQ-033 Bench SHALL assert clear with select = 1 -> ready low for exactly 8 cycles, request not accepted, then reads of all addresses return 8'h00.
REQ-034 Bench SHALL write 8'h5C to address 7 then read address 7 on the next edge -> data_output = 8'h5C.
REQ-035 Bench SHALL fill memory with 8'hFF, start clear, assert rst after 3 sweep cycles -> addresses 0..2 read 8'h00, 3..7 read 8'hFF, data_output = 0 and valid = 0 after reset.
REQ-036 Bench SHALL rerun REQ-031 and REQ-033 with DATA_W = 16, ADDR_W = 5 -> same behaviour, clear lasts 32 cycles.
